// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit CPU datapath blocks.
//   - DEFAULT_DATA_W : width of the shared 9-bit data multiplexor.
//   - arb_state_t    : state encoding of the mux arbiter FSM.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DEFAULT_DATA_W = 32'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mux_arbiter_mux.sv
// -----------------------------------------------------------------------------
// Multiplexor
// The shared 2:1 data multiplexor of the datapath.
// Ports:
//   in0  : data selected when sel = 0
//   in1  : data selected when sel = 1
//   sel  : select
//   dout : selected data
// -----------------------------------------------------------------------------
module Multiplexor #(
    parameter int WIDTH = 32'd9
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] dout
);

    // Plain 2:1 selection.
    always_comb begin
        dout = in0;
        if (sel) begin
            dout = in1;
        end else begin
            dout = in0;
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// -----------------------------------------------------------------------------
// mux_arbiter
// Round-robin arbiter/sequencer for the shared 2:1 data mux. Grants the path
// to requester A or B for a whole burst, drives the mux select and presents
// the selected beat through one registered valid/ready output stage. A beat
// counter forces a handoff when the owner would otherwise starve a waiting
// requester.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   validA/dataINA/lastA/readyA  : requester A handshake
//   validB/dataINB/lastB/readyB  : requester B handshake
//   dataOUT/validOUT/lastOUT     : registered output beat
//   readyOUT                     : consumer accepts the output beat
//   sel                          : mux select (1 only while B owns the path)
//   busy                         : a grant is held
// -----------------------------------------------------------------------------
module mux_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MAX_BURST = 32'd4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validA,
    input  logic [DATA_W-1:0] dataINA,
    input  logic              lastA,
    output logic              readyA,
    input  logic              validB,
    input  logic [DATA_W-1:0] dataINB,
    input  logic              lastB,
    output logic              readyB,
    output logic [DATA_W-1:0] dataOUT,
    output logic              validOUT,
    output logic              lastOUT,
    input  logic              readyOUT,
    output logic              sel,
    output logic              busy
);

    localparam int CNT_W = (MAX_BURST > 32'd1) ? $clog2(MAX_BURST) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(MAX_BURST - 32'd1);

    arb_state_t        state_r;
    arb_state_t        next_state_s;
    logic              lastgrant_r;
    logic [CNT_W-1:0]  beatcnt_r;
    logic [DATA_W-1:0] dataout_r;
    logic              validout_r;
    logic              lastout_r;

    logic [DATA_W-1:0] mux_data_s;
    logic              sel_s;
    logic              can_load_s;
    logic              own_valid_s;
    logic              own_last_s;
    logic              other_valid_s;
    logic              accept_s;
    logic              forced_s;
    logic              release_s;

    // The external mux follows the state register, so it is aligned with ready.
    assign sel_s      = (state_r == OWN_B);
    assign can_load_s = !validout_r || readyOUT;

    Multiplexor #(
        .WIDTH (DATA_W)
    ) u_mux (
        .in0  (dataINA),
        .in1  (dataINB),
        .sel  (sel_s),
        .dout (mux_data_s)
    );

    // Decode the current owner's and the other requester's handshake inputs.
    always_comb begin
        own_valid_s   = 1'b0;
        own_last_s    = 1'b0;
        other_valid_s = 1'b0;
        case (state_r)
            OWN_A: begin
                own_valid_s   = validA;
                own_last_s    = lastA;
                other_valid_s = validB;
            end
            OWN_B: begin
                own_valid_s   = validB;
                own_last_s    = lastB;
                other_valid_s = validA;
            end
            default: begin
                own_valid_s   = 1'b0;
                own_last_s    = 1'b0;
                other_valid_s = 1'b0;
            end
        endcase
    end

    assign accept_s  = own_valid_s && can_load_s;
    // Forcing only applies when the other side is actually waiting; a lone
    // owner keeps streaming with the counter parked at its top value.
    assign forced_s  = (beatcnt_r == CNT_TOP) && other_valid_s;
    assign release_s = accept_s && (own_last_s || forced_s);

    // Next-state arbitration; a release hands over directly when the other waits.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (validA && validB) begin
                    next_state_s = lastgrant_r ? OWN_A : OWN_B;
                end else if (validA) begin
                    next_state_s = OWN_A;
                end else if (validB) begin
                    next_state_s = OWN_B;
                end else begin
                    next_state_s = IDLE;
                end
            end
            OWN_A: begin
                if (release_s) begin
                    next_state_s = validB ? OWN_B : IDLE;
                end else begin
                    next_state_s = OWN_A;
                end
            end
            OWN_B: begin
                if (release_s) begin
                    next_state_s = validA ? OWN_A : IDLE;
                end else begin
                    next_state_s = OWN_B;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Last owner; resets to B so that A wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastgrant_r <= 1'b1;
        end else if (release_s) begin
            lastgrant_r <= (state_r == OWN_B);
        end else begin
            lastgrant_r <= lastgrant_r;
        end
    end

    // Beat counter, cleared on release and saturating at MAX_BURST-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            beatcnt_r <= {CNT_W{1'b0}};
        end else if (release_s) begin
            beatcnt_r <= {CNT_W{1'b0}};
        end else if (accept_s && (beatcnt_r != CNT_TOP)) begin
            beatcnt_r <= beatcnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            beatcnt_r <= beatcnt_r;
        end
    end

    // Output stage: load on accept, drain on consumer ready, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            dataout_r  <= {DATA_W{1'b0}};
            validout_r <= 1'b0;
            lastout_r  <= 1'b0;
        end else if (accept_s) begin
            dataout_r  <= mux_data_s;
            validout_r <= 1'b1;
            lastout_r  <= own_last_s || forced_s;
        end else if (readyOUT) begin
            dataout_r  <= dataout_r;
            validout_r <= 1'b0;
            lastout_r  <= lastout_r;
        end else begin
            dataout_r  <= dataout_r;
            validout_r <= validout_r;
            lastout_r  <= lastout_r;
        end
    end

    assign readyA   = (state_r == OWN_A) && can_load_s;
    assign readyB   = (state_r == OWN_B) && can_load_s;
    assign sel      = sel_s;
    assign busy     = (state_r != IDLE);
    assign dataOUT  = dataout_r;
    assign validOUT = validout_r;
    assign lastOUT  = lastout_r;

endmodule

// File: tb/tb_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_arbiter
// Cycle-accurate vector table for mux_arbiter (MAX_BURST = 4) plus an output
// scoreboard: every beat expected to be accepted is queued when driven and
// compared when the consumer takes it from the output stage.
// -----------------------------------------------------------------------------
module tb_mux_arbiter;

    localparam int W  = 9;
    localparam int NV = 46;

    logic         clk;
    logic         rst;
    logic         validA, lastA, readyA;
    logic [W-1:0] dataINA;
    logic         validB, lastB, readyB;
    logic [W-1:0] dataINB;
    logic [W-1:0] dataOUT;
    logic         validOUT, lastOUT, readyOUT;
    logic         sel, busy;

    mux_arbiter #(.DATA_W(W), .MAX_BURST(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .validA   (validA),
        .dataINA  (dataINA),
        .lastA    (lastA),
        .readyA   (readyA),
        .validB   (validB),
        .dataINB  (dataINB),
        .lastB    (lastB),
        .readyB   (readyB),
        .dataOUT  (dataOUT),
        .validOUT (validOUT),
        .lastOUT  (lastOUT),
        .readyOUT (readyOUT),
        .sel      (sel),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         rst;
        logic         va;
        logic [W-1:0] da;
        logic         la;
        logic         vb;
        logic [W-1:0] db;
        logic         lb;
        logic         ro;
        logic         xra;
        logic         xrb;
        logic         xsel;
        logic         xbusy;
        logic         xvo;
        logic [W-1:0] xdo;
        logic         xlo;
        logic         frc;   // accepted beat of this cycle is a forced handoff
    } vec_t;

    vec_t          vecs [NV];
    logic [W:0]    sb [$];   // {data, last}
    int            n_tests = 0;
    int            n_fail  = 0;
    logic          mon_en  = 1'b0;

    function automatic vec_t mk(
        input logic r, input logic va, input logic [W-1:0] da, input logic la,
        input logic vb, input logic [W-1:0] db, input logic lb, input logic ro,
        input logic xra, input logic xrb, input logic xsel, input logic xbusy,
        input logic xvo, input logic [W-1:0] xdo, input logic xlo, input logic frc);
        vec_t v;
        v.rst = r;   v.va = va;   v.da = da;   v.la = la;
        v.vb = vb;   v.db = db;   v.lb = lb;   v.ro = ro;
        v.xra = xra; v.xrb = xrb; v.xsel = xsel; v.xbusy = xbusy;
        v.xvo = xvo; v.xdo = xdo; v.xlo = xlo; v.frc = frc;
        return v;
    endfunction

    // Scoreboard: a beat leaves the output stage when validOUT && readyOUT.
    always @(negedge clk) begin
        if (mon_en && validOUT === 1'b1 && readyOUT === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: got data=%h last=%b, required no beat", dataOUT, lastOUT);
            end else begin
                logic [W:0] e;
                e = sb.pop_front();
                if ({dataOUT, lastOUT} !== e) begin
                    n_fail++;
                    $display("FAIL sb_beat: got data=%h last=%b, required data=%h last=%b",
                             dataOUT, lastOUT, e[W:1], e[0]);
                end
            end
        end
    end

    initial begin
        // Single A burst.
        vecs[0]  = mk(1,0,9'h000,0, 0,9'h000,0,0, 0,0,0,0, 0,9'h000,0,0);
        vecs[1]  = mk(0,1,9'h101,0, 0,9'h000,0,1, 0,0,0,0, 0,9'h000,0,0);
        vecs[2]  = mk(0,1,9'h101,0, 0,9'h000,0,1, 1,0,0,1, 0,9'h000,0,0);
        vecs[3]  = mk(0,1,9'h0AA,0, 0,9'h000,0,1, 1,0,0,1, 1,9'h101,0,0);
        vecs[4]  = mk(0,1,9'h1FF,1, 0,9'h000,0,1, 1,0,0,1, 1,9'h0AA,0,0);
        vecs[5]  = mk(0,0,9'h000,0, 0,9'h000,0,1, 0,0,0,0, 1,9'h1FF,1,0);
        vecs[6]  = mk(0,0,9'h000,0, 0,9'h000,0,1, 0,0,0,0, 0,9'h1FF,1,0);
        // Forced handoff A->B after 4 beats, then back to A after B's last.
        vecs[7]  = mk(0,1,9'h010,0, 0,9'h000,0,1, 0,0,0,0, 0,9'h1FF,1,0);
        vecs[8]  = mk(0,1,9'h010,0, 1,9'h020,0,1, 1,0,0,1, 0,9'h1FF,1,0);
        vecs[9]  = mk(0,1,9'h011,0, 1,9'h020,0,1, 1,0,0,1, 1,9'h010,0,0);
        vecs[10] = mk(0,1,9'h012,0, 1,9'h020,0,1, 1,0,0,1, 1,9'h011,0,0);
        vecs[11] = mk(0,1,9'h013,0, 1,9'h020,0,1, 1,0,0,1, 1,9'h012,0,1);
        vecs[12] = mk(0,1,9'h014,0, 1,9'h020,0,1, 0,1,1,1, 1,9'h013,1,0);
        vecs[13] = mk(0,1,9'h014,0, 1,9'h021,1,1, 0,1,1,1, 1,9'h020,0,0);
        vecs[14] = mk(0,1,9'h014,0, 0,9'h000,0,1, 1,0,0,1, 1,9'h021,1,0);
        vecs[15] = mk(0,1,9'h015,1, 0,9'h000,0,1, 1,0,0,1, 1,9'h014,0,0);
        vecs[16] = mk(0,0,9'h000,0, 0,9'h000,0,1, 0,0,0,0, 1,9'h015,1,0);
        // Backpressure for 3 cycles mid-burst.
        vecs[17] = mk(0,1,9'h030,0, 0,9'h000,0,1, 0,0,0,0, 0,9'h015,1,0);
        vecs[18] = mk(0,1,9'h030,0, 0,9'h000,0,1, 1,0,0,1, 0,9'h015,1,0);
        vecs[19] = mk(0,1,9'h031,0, 0,9'h000,0,1, 1,0,0,1, 1,9'h030,0,0);
        vecs[20] = mk(0,1,9'h032,0, 0,9'h000,0,0, 0,0,0,1, 1,9'h031,0,0);
        vecs[21] = mk(0,1,9'h032,0, 0,9'h000,0,0, 0,0,0,1, 1,9'h031,0,0);
        vecs[22] = mk(0,1,9'h032,0, 0,9'h000,0,0, 0,0,0,1, 1,9'h031,0,0);
        vecs[23] = mk(0,1,9'h032,0, 0,9'h000,0,1, 1,0,0,1, 1,9'h031,0,0);
        vecs[24] = mk(0,1,9'h033,1, 0,9'h000,0,1, 1,0,0,1, 1,9'h032,0,0);
        vecs[25] = mk(0,0,9'h000,0, 0,9'h000,0,1, 0,0,0,0, 1,9'h033,1,0);
        // A alone for 8 beats: no forced release.
        vecs[26] = mk(0,1,9'h040,0, 0,9'h000,0,1, 0,0,0,0, 0,9'h033,1,0);
        vecs[27] = mk(0,1,9'h040,0, 0,9'h000,0,1, 1,0,0,1, 0,9'h033,1,0);
        for (int k = 1; k <= 7; k++) begin
            vecs[27+k] = mk(0,1,9'h040 + W'(k),0, 0,9'h000,0,1, 1,0,0,1,
                            1,9'h040 + W'(k-1),0,0);
        end
        // Owner drops valid: grant held while B waits; then saturated counter forces.
        vecs[35] = mk(0,0,9'h000,0, 1,9'h050,0,1, 1,0,0,1, 1,9'h047,0,0);
        vecs[36] = mk(0,0,9'h000,0, 1,9'h050,0,1, 1,0,0,1, 0,9'h047,0,0);
        vecs[37] = mk(0,1,9'h049,0, 1,9'h050,0,1, 1,0,0,1, 0,9'h047,0,1);
        vecs[38] = mk(0,0,9'h000,0, 1,9'h050,0,1, 0,1,1,1, 1,9'h049,1,0);
        // Reset in OWN_B with a beat in flight, then tie: A wins, direct handoff to B.
        vecs[39] = mk(1,0,9'h000,0, 1,9'h051,0,0, 0,0,1,1, 1,9'h050,0,0);
        vecs[40] = mk(0,1,9'h060,0, 1,9'h070,0,1, 0,0,0,0, 0,9'h000,0,0);
        vecs[41] = mk(0,1,9'h060,1, 1,9'h070,0,1, 1,0,0,1, 0,9'h000,0,0);
        vecs[42] = mk(0,0,9'h000,0, 1,9'h070,0,1, 0,1,1,1, 1,9'h060,1,0);
        vecs[43] = mk(0,0,9'h000,0, 1,9'h071,1,1, 0,1,1,1, 1,9'h070,0,0);
        vecs[44] = mk(0,0,9'h000,0, 0,9'h000,0,1, 0,0,0,0, 1,9'h071,1,0);
        vecs[45] = mk(0,0,9'h000,0, 0,9'h000,0,1, 0,0,0,0, 0,9'h071,1,0);

        rst = 1'b1;
        validA = 1'b0; dataINA = '0; lastA = 1'b0;
        validB = 1'b0; dataINB = '0; lastB = 1'b0;
        readyOUT = 1'b0;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        for (int i = 0; i < NV; i++) begin
            logic [14:0] got;
            logic [14:0] exp;
            @(posedge clk);
            #1;
            rst      = vecs[i].rst;
            validA   = vecs[i].va;
            dataINA  = vecs[i].da;
            lastA    = vecs[i].la;
            validB   = vecs[i].vb;
            dataINB  = vecs[i].db;
            lastB    = vecs[i].lb;
            readyOUT = vecs[i].ro;
            if (vecs[i].rst) begin
                sb.delete();
            end
            if (vecs[i].va && vecs[i].xra) begin
                sb.push_back({vecs[i].da, vecs[i].la | vecs[i].frc});
            end else if (vecs[i].vb && vecs[i].xrb) begin
                sb.push_back({vecs[i].db, vecs[i].lb | vecs[i].frc});
            end
            @(negedge clk);
            got = {readyA, readyB, sel, busy, validOUT, dataOUT, lastOUT};
            exp = {vecs[i].xra, vecs[i].xrb, vecs[i].xsel, vecs[i].xbusy,
                   vecs[i].xvo, vecs[i].xdo, vecs[i].xlo};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL vec%0d: got rA=%b rB=%b sel=%b busy=%b vO=%b d=%h lO=%b, required rA=%b rB=%b sel=%b busy=%b vO=%b d=%h lO=%b",
                         i, got[14], got[13], got[12], got[11], got[10], got[9:1], got[0],
                         exp[14], exp[13], exp[12], exp[11], exp[10], exp[9:1], exp[0]);
            end
        end

        @(posedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d beats outstanding, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester arbiter and sequencer for the shared 9-bit 2:1 data multiplexor of the 8-bit CPU datapath. It grants the path to requester A or B with round-robin fairness and holds the grant for the whole burst. It drives the mux select and presents the selected stream through one registered output stage with a valid/ready handshake. A beat counter forces a handoff when one requester would otherwise starve the other.

## Interface
Parameters:
- DATA_W, 9: data width; matches the shared mux width.
- MAX_BURST, 4: maximum beats per grant while the other requester is waiting; must be ≥1.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- validA  in  1  requester A has a beat.
- dataINA  in  DATA_W  requester A data.
- lastA  in  1  A's beat ends its burst.
- readyA  out  1  A's beat is accepted this cycle.
- validB, dataINB, lastB, readyB: same as A, for requester B.
- dataOUT  out  DATA_W  registered output data.
- validOUT  out  1  dataOUT holds a beat.
- lastOUT  out  1  segment end, either a real last or a forced handoff.
- readyOUT  in  1  consumer accepts the output beat.
- sel  out  1  mux select: 0 = A, 1 = B. Equals 1 only in OWN_B.
- busy  out  1  state is not IDLE.

## Operation
- States:
  - IDLE: no grant.
  - OWN_A: A holds the grant.
  - OWN_B: B holds the grant.
- lastGrant register (0 = A, 1 = B) records the last owner.
- IDLE arbitration:
  - Only A valid → OWN_A. Only B valid → OWN_B.
  - Both valid → the requester that is not lastGrant.
  - Neither valid → stay in IDLE.
- Output stage can load when `!validOUT || readyOUT`.
- readyA = (state==OWN_A) && output stage can load. readyB is the same for OWN_B. Both are 0 in IDLE.
- A beat is accepted when owner valid && owner ready. On acceptance:
  - dataOUT ← owner data and validOUT ← 1.
  - beatCnt increments.
  - lastOUT ← owner last, OR forced.
- Forced: beatCnt reaches MAX_BURST on this beat (beatCnt == MAX_BURST-1) and the other requester's valid is high this cycle.
- Release happens on an accepted beat that has last=1 or is forced. On release:
  - beatCnt ← 0.
  - lastGrant ← current owner.
  - Next state is OWN_other if the other is valid this cycle, otherwise IDLE. There is no bubble on a direct handoff.
- If the owner drops valid mid-burst, the grant is held with no timeout. The other requester waits.
- If MAX_BURST is reached and the other requester is idle, there is no forced release. The counter saturates at MAX_BURST-1 until the other requester asserts or the burst ends.
- If the consumer accepts (readyOUT) and no new beat loads, validOUT ← 0.
- dataOUT and lastOUT hold their values while validOUT && !readyOUT.
- Reset values: state IDLE, lastGrant 1 (so A wins the first tie), beatCnt 0, dataOUT 0, validOUT 0, lastOUT 0, sel 0, busy 0, readyA/readyB 0.
- Reset mid-burst drops the in-flight output beat. The next cycle starts from the reset state.

## Timing
- Request at cycle t while in IDLE: state OWN at t+1, ready high at t+1, first beat accepted at t+1, validOUT at t+2. Minimum latency from idle is 2 cycles.
- Back-to-back throughput is 1 beat/cycle while readyOUT=1, including across a direct handoff.
- sel and busy are combinational decodes of the state register, so they change one cycle after the arbitration decision. The external mux is aligned with ready.
- Output backpressure: readyOUT=0 with validOUT=1 drops owner ready in the same cycle. No beat is lost or duplicated.

## Structure
- Shared package `cpu_pkg` holds:
  - the state encoding constants (IDLE=2'd0, OWN_A=2'd1, OWN_B=2'd2);
  - the DATA_W default of 9.
- One sub-module: the existing `Multiplexor` instance performs the A/B data selection, driven by sel. The FSM, counter and output register live in mux_arbiter.

## Test plan
- Single A burst: A sends 0x101, 0x0AA, 0x1FF (last) with readyOUT=1 → dataOUT shows the same sequence on cycles t+2..t+4, lastOUT on 0x1FF, then IDLE. sel stays 0 throughout.
- Simultaneous first request: A and B valid at cycle 1 after reset → A granted. After A's last, B is granted directly with no bubble and sel goes to 1.
- Forced handoff: MAX_BURST=4, A streams 6 beats without last while B waits → 4th A beat has lastOUT=1, then B's beats follow. A resumes after B's last.
- Backpressure: readyOUT=0 for 3 cycles mid-burst → dataOUT, validOUT and lastOUT hold, readyA=0, and no beat is dropped or duplicated when readyOUT returns.
- No starvation when alone: A sends 8 beats without last and B idle → no forced release, and all 8 beats pass with lastOUT=0.
- Reset mid-burst: assert rst while in OWN_B with validOUT=1 → next cycle all outputs are at their reset values. After rst clears, A and B tie and A wins.
